// File: rtl/fir_axil_sequencer_if.sv
`timescale 1ns/1ps
// fir_axil_sequencer_if: AXI-Lite write/read channel bundle (no B channel) between the
// FIR sequencer (master) and the FIR engine's configuration port (slave).
interface fir_axil_sequencer_if #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
);
  logic                   awvalid;
  logic [pADDR_WIDTH-1:0] awaddr;
  logic                   awready;
  logic                   wvalid;
  logic [pDATA_WIDTH-1:0] wdata;
  logic                   wready;
  logic                   arvalid;
  logic [pADDR_WIDTH-1:0] araddr;
  logic                   arready;
  logic                   rready;
  logic                   rvalid;
  logic [pDATA_WIDTH-1:0] rdata;

  modport master (
    output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    input  awready, wready, arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    output awready, wready, arready, rvalid, rdata
  );
endinterface

// File: rtl/fir_axil_sequencer.sv
`timescale 1ns/1ps
// fir_axil_sequencer: shadows FIR taps/length, writes them plus ap_start over AXI-Lite and
// polls ap_done with timeout. Define FIR_SEQ_READBACK_EN to verify taps by readback.
module fir_axil_sequencer #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11,
  parameter int POLL_GAP    = 4,
  parameter int POLL_MAX    = 1024
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   cfg_we,
  input  logic [3:0]             cfg_addr,
  input  logic [pDATA_WIDTH-1:0] cfg_wdata,
  input  logic                   go,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [15:0]            poll_cnt,
  fir_axil_sequencer_if.master   axil
);

  typedef enum logic [3:0] {
    IDLE,
    WR_TAP,
`ifdef FIR_SEQ_READBACK_EN
    VERIFY_AR,
    VERIFY_R,
`endif
    WR_LEN,
    WR_START,
    POLL_WAIT,
    POLL_AR,
    POLL_R,
    FIN
  } state_t;

  state_t                 state;
  state_t                 next_state;
  logic [pDATA_WIDTH-1:0] taps [Tape_Num];
  logic [pDATA_WIDTH-1:0] len;
  logic [3:0]             idx;
  logic                   aw_done;
  logic                   w_done;
  logic [15:0]            gap_cnt;

  logic                   go_accept;
  logic                   is_write;
  logic                   aw_hs;
  logic                   w_hs;
  logic                   beat_done;
  logic                   ar_hs;
  logic                   r_hs;
  logic                   last_tap;
  logic                   gap_last;
  logic                   poll_timeout;
  logic [pADDR_WIDTH-1:0] tap_addr;

  assign go_accept    = go && !busy;
  assign is_write     = (state == WR_TAP) || (state == WR_LEN) || (state == WR_START);
  assign aw_hs        = axil.awvalid && axil.awready;
  assign w_hs         = axil.wvalid && axil.wready;
  assign beat_done    = (aw_done || aw_hs) && (w_done || w_hs);
  assign ar_hs        = axil.arvalid && axil.arready;
  assign r_hs         = axil.rready && axil.rvalid;
  assign last_tap     = (idx == 4'(Tape_Num - 1));
  assign gap_last     = (32'(gap_cnt) == POLL_GAP - 1);
  assign poll_timeout = (32'(poll_cnt) >= POLL_MAX);
  assign tap_addr     = pADDR_WIDTH'(12'h040) + (pADDR_WIDTH'(idx) << 2);

`ifdef FIR_SEQ_READBACK_EN
  logic rd_mismatch;
  assign rd_mismatch = (axil.rdata != taps[idx]);
`endif

  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, FIN: begin
        if (go_accept) next_state = WR_TAP;
        else           next_state = IDLE;
      end
      WR_TAP: begin
`ifdef FIR_SEQ_READBACK_EN
        if (beat_done && last_tap) next_state = VERIFY_AR;
`else
        if (beat_done && last_tap) next_state = WR_LEN;
`endif
      end
`ifdef FIR_SEQ_READBACK_EN
      VERIFY_AR: if (ar_hs) next_state = VERIFY_R;
      VERIFY_R: begin
        if (r_hs) begin
          if (rd_mismatch)   next_state = FIN;
          else if (last_tap) next_state = WR_LEN;
          else               next_state = VERIFY_AR;
        end
      end
`endif
      WR_LEN:    if (beat_done) next_state = WR_START;
      WR_START:  if (beat_done) next_state = POLL_WAIT;
      POLL_WAIT: if (gap_last) next_state = POLL_AR;
      POLL_AR:   if (ar_hs) next_state = POLL_R;
      POLL_R: begin
        if (r_hs) begin
          if (axil.rdata[1] || poll_timeout) next_state = FIN;
          else                               next_state = POLL_WAIT;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Valids come straight from the state and the per-channel "handshake seen" flags, so
  // address/data stay frozen for the whole beat and each valid drops right after its own handshake.
  always_comb begin
    axil.awvalid = 1'b0;
    axil.awaddr  = '0;
    axil.wvalid  = 1'b0;
    axil.wdata   = '0;
    axil.arvalid = 1'b0;
    axil.araddr  = '0;
    axil.rready  = 1'b0;
    busy         = (state != IDLE) && (state != FIN);
    done         = (state == FIN);
    case (state)
      WR_TAP: begin
        axil.awvalid = !aw_done;
        axil.wvalid  = !w_done;
        axil.awaddr  = tap_addr;
        axil.wdata   = taps[idx];
      end
`ifdef FIR_SEQ_READBACK_EN
      VERIFY_AR: begin
        axil.arvalid = 1'b1;
        axil.araddr  = tap_addr;
      end
      VERIFY_R: axil.rready = 1'b1;
`endif
      WR_LEN: begin
        axil.awvalid = !aw_done;
        axil.wvalid  = !w_done;
        axil.awaddr  = pADDR_WIDTH'(12'h010);
        axil.wdata   = len;
      end
      WR_START: begin
        axil.awvalid = !aw_done;
        axil.wvalid  = !w_done;
        axil.wdata   = pDATA_WIDTH'(1);
      end
      POLL_AR: axil.arvalid = 1'b1;
      POLL_R:  axil.rready  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      for (int i = 0; i < Tape_Num; i++) taps[i] <= '0;
      len      <= '0;
      idx      <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      gap_cnt  <= '0;
      poll_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (cfg_we && !busy) begin
        for (int i = 0; i < Tape_Num; i++) begin
          if (cfg_addr == 4'(i)) taps[i] <= cfg_wdata;
        end
        if (cfg_addr == 4'd15) len <= cfg_wdata;
      end
      if (go_accept) begin
        err      <= 1'b0;
        poll_cnt <= '0;
        idx      <= '0;
      end
      if (is_write) begin
        if (beat_done) begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end else begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
      end
      // idx wraps to 0 after the last tap so an optional readback pass starts from tap 0.
      if (state == WR_TAP && beat_done) idx <= last_tap ? 4'd0 : idx + 4'd1;
`ifdef FIR_SEQ_READBACK_EN
      if (state == VERIFY_R && r_hs) begin
        if (!last_tap)  idx <= idx + 4'd1;
        if (rd_mismatch) err <= 1'b1;
      end
`endif
      gap_cnt <= (state == POLL_WAIT) ? gap_cnt + 16'd1 : 16'd0;
      if (state == POLL_AR && ar_hs && poll_cnt != 16'hFFFF) poll_cnt <= poll_cnt + 16'd1;
      if (state == POLL_R && r_hs && !axil.rdata[1] && poll_timeout) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_axil_sequencer.sv
`timescale 1ns/1ps
// tb_fir_axil_sequencer: randomized AXI-Lite slave plus a transaction-level model of the
// expected write list, poll count and error outcome of each sequencer run.
module tb_fir_axil_sequencer;
  localparam int TAPS     = 11;
  localparam int POLL_GAP = 4;
  localparam int POLL_MAX = 8;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        go;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] poll_cnt;

  fir_axil_sequencer_if #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) axil ();

  fir_axil_sequencer #(
    .pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(TAPS), .POLL_GAP(POLL_GAP), .POLL_MAX(POLL_MAX)
  ) dut (
    .axis_clk(clk), .axis_rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .go(go), .busy(busy), .done(done), .err(err),
    .poll_cnt(poll_cnt), .axil(axil)
  );

  int tests = 0;
  int failures = 0;

  logic [31:0] model_taps [16];
  logic [31:0] model_len;

  // Slave configuration and observations.
  int aw_max, w_max, rd_max, done_after, corrupt;
  bit fixed_lat;
  int aw_lat, aw_cnt, w_lat, w_cnt, ar_lat, ar_cnt, r_lat, r_cnt;
  bit rd_pending;
  logic [31:0] r_data;
  int poll_num, done_seen, viol, idle_run, min_gap, cycle;
  logic [11:0] aw_q [$];
  logic [31:0] w_q [$];
  int          aw_cyc [$];
  logic        last_awvalid, last_wvalid, last_arvalid, last_rready;
  logic [11:0] last_awaddr, last_araddr;
  logic [31:0] last_wdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pickLat(input int mx, input bit fx);
    if (fx) return mx;
    return $urandom_range(0, mx);
  endfunction

  function automatic logic [31:0] lookupWrite(input logic [11:0] a);
    logic [31:0] r;
    r = 32'h0;
    for (int j = 0; j < aw_q.size() && j < w_q.size(); j++) if (aw_q[j] == a) r = w_q[j];
    return r;
  endfunction

  // Slave model: acts at negedges; values seen here were the ones present at the previous posedge.
  initial begin
    axil.awready = 0; axil.wready = 0; axil.arready = 0; axil.rvalid = 0; axil.rdata = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0; rd_pending = 0; cycle = 0;
    aw_lat = 0; w_lat = 0; ar_lat = 0; r_lat = 0; done_seen = 0; viol = 0; idle_run = 0;
    last_awvalid = 0; last_wvalid = 0; last_arvalid = 0; last_rready = 0;
    last_awaddr = 0; last_araddr = 0; last_wdata = 0;
    forever begin
      @(negedge clk);
      if (rst_n && last_awvalid && axil.awready) begin
        aw_q.push_back(last_awaddr); aw_cyc.push_back(cycle);
        aw_cnt = 0; aw_lat = pickLat(aw_max, fixed_lat);
      end else if (rst_n && last_awvalid && (!axil.awvalid || axil.awaddr != last_awaddr)) viol++;
      if (rst_n && last_wvalid && axil.wready) begin
        w_q.push_back(last_wdata);
        w_cnt = 0; w_lat = pickLat(w_max, fixed_lat);
      end else if (rst_n && last_wvalid && (!axil.wvalid || axil.wdata != last_wdata)) viol++;
      if (rst_n && axil.rvalid && last_rready) rd_pending = 0;
      if (rst_n && last_arvalid && axil.arready) begin
        if (last_araddr == 12'h000) begin
          poll_num++;
          r_data = $urandom & ~32'h2;
          if (done_after != 0 && poll_num >= done_after) r_data = r_data | 32'h2;
        end else begin
          r_data = lookupWrite(last_araddr);
          if (corrupt >= 0 && last_araddr == 12'(32'h40 + 4 * corrupt)) r_data = r_data ^ 32'h1;
        end
        rd_pending = 1; r_cnt = 0; r_lat = pickLat(rd_max, fixed_lat);
        ar_cnt = 0; ar_lat = pickLat(rd_max, fixed_lat);
      end else if (rst_n && last_arvalid && (!axil.arvalid || axil.araddr != last_araddr)) viol++;
      if (!rst_n) rd_pending = 0;
      axil.awready = axil.awvalid && (aw_cnt >= aw_lat);
      if (axil.awvalid) aw_cnt++;
      axil.wready = axil.wvalid && (w_cnt >= w_lat);
      if (axil.wvalid) w_cnt++;
      axil.arready = axil.arvalid && (ar_cnt >= ar_lat);
      if (axil.arvalid) ar_cnt++;
      axil.rvalid = rd_pending && (r_cnt >= r_lat);
      axil.rdata  = axil.rvalid ? r_data : ($urandom | 32'h2);
      if (rd_pending) r_cnt++;
      if (axil.arvalid && !last_arvalid && axil.araddr == 12'h000 && idle_run < min_gap) min_gap = idle_run;
      if (busy && !axil.awvalid && !axil.wvalid && !axil.arvalid && !axil.rready) idle_run++;
      else idle_run = 0;
      if (done) done_seen++;
      last_awvalid = axil.awvalid; last_awaddr = axil.awaddr;
      last_wvalid  = axil.wvalid;  last_wdata  = axil.wdata;
      last_arvalid = axil.arvalid; last_araddr = axil.araddr;
      last_rready  = axil.rready;
      cycle++;
    end
  end

  task automatic cfgWrite(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk); #1;
    cfg_we = 1; cfg_addr = a; cfg_wdata = d;
    if (!busy) begin
      if (a < TAPS) model_taps[a] = d;
      else if (a == 4'd15) model_len = d;
    end
    @(negedge clk); #1;
    cfg_we = 0;
  endtask

  task automatic checkResetState(input string p);
    checkOutput({p, "_awvalid"}, axil.awvalid, 0);
    checkOutput({p, "_wvalid"}, axil.wvalid, 0);
    checkOutput({p, "_arvalid"}, axil.arvalid, 0);
    checkOutput({p, "_rready"}, axil.rready, 0);
    checkOutput({p, "_awaddr"}, axil.awaddr, 0);
    checkOutput({p, "_wdata"}, axil.wdata, 0);
    checkOutput({p, "_araddr"}, axil.araddr, 0);
    checkOutput({p, "_busy"}, busy, 0);
    checkOutput({p, "_done"}, done, 0);
    checkOutput({p, "_err"}, err, 0);
    checkOutput({p, "_poll_cnt"}, poll_cnt, 0);
  endtask

  task automatic applyStimulus(input string name, input int da, input int awm, input int wm,
                               input int rdm, input bit fx, input bit inject, input bit same_wr,
                               input int corrupt_i);
    logic [31:0] exp_addr [$];
    logic [31:0] exp_data [$];
    logic [31:0] newv;
    int exp_err, exp_poll, pre_done, n;
    bit got;
    done_after = da; aw_max = awm; w_max = wm; rd_max = rdm; fixed_lat = fx; corrupt = corrupt_i;
    aw_lat = pickLat(awm, fx); w_lat = pickLat(wm, fx); ar_lat = pickLat(rdm, fx);
    aw_q.delete(); w_q.delete(); aw_cyc.delete(); poll_num = 0; min_gap = 1000000; viol = 0;
    @(negedge clk); #1;
    go = 1;
    if (same_wr) begin
      newv = $urandom;
      cfg_we = 1; cfg_addr = 4'd0; cfg_wdata = newv;
      if (!busy) model_taps[0] = newv;
    end
    for (int i = 0; i < TAPS; i++) begin
      exp_addr.push_back(32'h40 + 4 * i); exp_data.push_back(model_taps[i]);
    end
    if (corrupt_i < 0) begin
      exp_addr.push_back(32'h10); exp_data.push_back(model_len);
      exp_addr.push_back(32'h00); exp_data.push_back(32'h1);
    end
    if (corrupt_i >= 0) begin exp_err = 1; exp_poll = 0; end
    else if (da >= 1 && da <= POLL_MAX) begin exp_err = 0; exp_poll = da; end
    else begin exp_err = 1; exp_poll = POLL_MAX; end
    pre_done = done_seen;
    @(negedge clk); #1;
    go = 0; cfg_we = 0;
    checkOutput({name, "_busy_n1"}, busy, 1);
    checkOutput({name, "_awvalid_n1"}, axil.awvalid, 1);
    checkOutput({name, "_err_clr"}, err, 0);
    got = 0;
    for (int c = 0; c < 4000 && !got; c++) begin
      if (inject && c == 3) begin
        cfg_we = 1; cfg_addr = 4'($urandom_range(0, TAPS - 1)); cfg_wdata = $urandom;
        if (!busy) model_taps[cfg_addr] = cfg_wdata;
      end
      if (inject && c == 4) begin cfg_we = 0; go = 1; end
      if (inject && c == 5) go = 0;
      @(negedge clk); #1;
      if (done_seen != pre_done) got = 1;
    end
    checkOutput({name, "_finished"}, got, 1);
    checkOutput({name, "_busy_at_done"}, busy, 0);
    checkOutput({name, "_err"}, err, exp_err);
    checkOutput({name, "_poll_cnt"}, poll_cnt, exp_poll);
    repeat (3) @(negedge clk);
    #1;
    checkOutput({name, "_done_pulses"}, done_seen - pre_done, 1);
    checkOutput({name, "_err_sticky"}, err, exp_err);
    checkOutput({name, "_aw_count"}, aw_q.size(), exp_addr.size());
    checkOutput({name, "_w_count"}, w_q.size(), exp_data.size());
    n = exp_addr.size();
    for (int i = 0; i < n && i < aw_q.size() && i < w_q.size(); i++) begin
      checkOutput($sformatf("%s_wr%0d_addr", name, i), aw_q[i], exp_addr[i][11:0]);
      checkOutput($sformatf("%s_wr%0d_data", name, i), w_q[i], exp_data[i]);
    end
`ifndef FIR_SEQ_READBACK_EN
    if (fx && awm == 0 && wm == 0 && aw_cyc.size() == n)
      checkOutput({name, "_wr_span"}, aw_cyc[n-1] - aw_cyc[0], n - 1);
`endif
    if (exp_poll > 0) checkOutput({name, "_poll_gap"}, min_gap, POLL_GAP);
    checkOutput({name, "_protocol"}, viol, 0);
  endtask

  initial begin
    int fir_taps [TAPS];
    int pre;
    fir_taps = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    for (int i = 0; i < 16; i++) model_taps[i] = 0;
    model_len = 0;
    aw_max = 0; w_max = 0; rd_max = 0; done_after = 0; corrupt = -1; fixed_lat = 1;
    rst_n = 0; go = 0; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0;
    repeat (3) @(negedge clk);
    #1;
    checkResetState("reset");
    rst_n = 1;

    for (int i = 0; i < TAPS; i++) cfgWrite(4'(i), fir_taps[i]);
    cfgWrite(4'd15, 32'd600);
    applyStimulus("fir", 3, 0, 0, 0, 1, 0, 0, -1);

    applyStimulus("awslow", $urandom_range(1, POLL_MAX), 3, 0, 1, 1, 0, 0, -1);
    applyStimulus("timeout", 0, 1, 1, 1, 0, 0, 0, -1);
    applyStimulus("after_to", 2, 0, 0, 0, 1, 0, 0, -1);
    applyStimulus("inject", 1, 2, 2, 1, 0, 1, 0, -1);
    applyStimulus("samecyc", 1, 0, 0, 0, 1, 0, 1, -1);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < TAPS; i++) cfgWrite(4'(i), $urandom);
      cfgWrite(4'd15, $urandom_range(1, 4096));
      cfgWrite(4'(12 + r % 3), $urandom);
      applyStimulus($sformatf("rand%0d", r), $urandom_range(0, POLL_MAX + 2),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 0, 0, 0, -1);
    end

`ifdef FIR_SEQ_READBACK_EN
    applyStimulus("readback_ok", 2, 1, 0, 1, 0, 0, 0, -1);
    applyStimulus("readback_bad", 2, 0, 0, 1, 0, 0, 0, 4);
`endif

    // Abort a run mid tap-write; the shadow file must come back cleared.
    done_after = 0; aw_max = 0; w_max = 0; rd_max = 0; fixed_lat = 1; corrupt = -1;
    aw_lat = 0; w_lat = 0;
    aw_q.delete(); w_q.delete(); aw_cyc.delete();
    @(negedge clk); #1;
    go = 1;
    @(negedge clk); #1;
    go = 0;
    for (int c = 0; c < 100 && aw_q.size() < 5; c++) begin
      @(negedge clk); #1;
    end
    checkOutput("rst_at_idx5_addr", axil.awaddr, 12'h054);
    pre = done_seen;
    rst_n = 0;
    @(negedge clk); #1;
    checkResetState("midrst");
    rst_n = 1;
    repeat (8) @(negedge clk);
    #1;
    checkOutput("midrst_no_done", done_seen - pre, 0);
    for (int i = 0; i < 16; i++) model_taps[i] = 0;
    model_len = 0;
    applyStimulus("post_rst", 1, 0, 0, 0, 1, 0, 0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
